multicycle_controller: RTL and testbench

Sequencing control unit for the multicycle RV32I core: a Moore FSM plus an ALU-function decoder. Each instruction is walked through fetch, decode, execute, memory and writeback steps over 3–5 cycles. Every mux-select and write-enable for the shared PC/IR/ALU/memory datapath is driven from this block. An optional memory-ready handshake stretches the memory-access states.

---
 rtl/mc_ctrl_pkg.sv | 54 +++++
 rtl/multicycle_controller_if.sv | 35 +++
 rtl/multicycle_controller_alu_decoder.sv | 32 +++
 rtl/multicycle_controller.sv | 140 ++++++++++++++
 tb/tb_multicycle_controller.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: state machine
// states, opcodes, and every datapath mux-select / ALU control code.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/multicycle_controller_if.sv
// Bundle between the controller and the shared PC/IR/ALU/memory datapath.
// The datapath (master) supplies instruction fields and status flags; the
// controller (slave) returns every select and enable.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    output op, funct3, funct7b5, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal, State
  );

  modport slave (
    input  op, funct3, funct7b5, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal, State
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU function decoder: turns the FSM's coarse ALUOp plus the instruction's
// funct fields into the concrete ALU operation.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op_b5,
  output logic [2:0] alu_control
);

  // Subtract only for R-type (op bit 5 set) with funct7 bit 5; addi never subtracts.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op_b5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing controller: Moore FSM driving every datapath
// select/enable, plus the ALU function decoder.
// Build option MC_CTRL_MEM_WAIT_EN: when defined, MemReady stretches FETCH,
// MEMREAD and MEMWRITE; when undefined, MemReady is treated as always high.
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.slave bus
);

  state_t     state_q, state_d;
  logic       mem_ready;
  logic       pc_update, branch;
  logic [1:0] alu_op;
  logic [2:0] alu_control;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign mem_ready = bus.MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  // State register; reset forces FETCH immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and Moore outputs; everything defaults to 0 and the state holds.
  always_comb begin
    state_d       = state_q;
    pc_update     = 1'b0;
    branch        = 1'b0;
    alu_op        = ALUOP_ADD;
    bus.AdrSrc    = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.ResultSrc = RES_ALUOUT;
    bus.ALUSrcA   = SRCA_PC;
    bus.ALUSrcB   = SRCB_RD2;
    bus.Illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        bus.IRWrite   = mem_ready;
        pc_update     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_IMM;
        state_d     = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        bus.AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        bus.ResultSrc = RES_READDATA;
        bus.RegWrite  = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        bus.ALUSrcA = SRCA_RD1;
        alu_op      = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_EXECUTEI: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_IMM;
        alu_op      = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegWrite = 1'b1;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_FOUR;
        pc_update   = 1'b1;
        state_d     = S_ALUWB;
      end
      S_BEQ: begin
        bus.ALUSrcA = SRCA_RD1;
        alu_op      = ALUOP_SUB;
        branch      = 1'b1;
        state_d     = S_FETCH;
      end
      S_ILLEGAL: begin
        bus.Illegal = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Immediate format depends only on the opcode, independent of state.
  always_comb begin
    case (bus.op)
      OP_SW:   bus.ImmSrc = IMM_S;
      OP_BEQ:  bus.ImmSrc = IMM_B;
      OP_JAL:  bus.ImmSrc = IMM_J;
      default: bus.ImmSrc = IMM_I;
    endcase
  end

  assign bus.PCWrite    = pc_update | (branch & bus.Zero);
  assign bus.State      = state_q;
  assign bus.ALUControl = alu_control;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op_b5       (bus.op[5]),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller. Expected values are hand
// derived per instruction class; wait-state expectations follow
// MC_CTRL_MEM_WAIT_EN in the same way the design build does.
module tb_multicycle_controller;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checkCount = 0;
  int   failCount  = 0;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic f7, input logic zero, input logic ready);
    bus.op       = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    bus.Zero     = zero;
    bus.MemReady = ready;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic checkState(input string tag, input logic [31:0] expected);
    checkOutput(tag, {28'd0, bus.State}, expected);
  endtask

  task automatic pulseReset(input string tag);
    reset = 1'b1;
    #1;
    checkState(tag, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int lwStates [5] = '{1, 2, 3, 4, 0};
  int lwReg    [5] = '{0, 0, 0, 1, 0};
  int lwRes    [5] = '{0, 0, 0, 1, 2};
  int lwAdr    [5] = '{0, 0, 1, 0, 0};

  initial begin
    reset = 1'b1;
    applyStimulus(OP_LW, 3'b000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkState("reset_state", 0);
    checkOutput("reset_alusrcb", bus.ALUSrcB, 2);
    checkOutput("reset_resultsrc", bus.ResultSrc, 2);
    checkOutput("reset_irwrite", bus.IRWrite, 1);
    checkOutput("reset_pcwrite", bus.PCWrite, 1);
    checkOutput("reset_regwrite", bus.RegWrite, 0);
    checkOutput("reset_memwrite", bus.MemWrite, 0);
    checkOutput("reset_alusrca", bus.ALUSrcA, 0);
    reset = 1'b0;

    // lw: 0 -> 1 -> 2 -> 3 -> 4 -> 0
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      checkState("lw_state", lwStates[i]);
      checkOutput("lw_regwrite", bus.RegWrite, lwReg[i]);
      checkOutput("lw_resultsrc", bus.ResultSrc, lwRes[i]);
      checkOutput("lw_adrsrc", bus.AdrSrc, lwAdr[i]);
    end

    // sw with MemReady low through the first three MEMWRITE cycles
    applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1);
    nextCycle();
    checkState("sw_decode", 1);
    checkOutput("sw_immsrc", bus.ImmSrc, 1);
    nextCycle();
    checkState("sw_memadr", 2);
    bus.MemReady = 1'b0;
`ifdef MC_CTRL_MEM_WAIT_EN
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkState("sw_wait_state", 5);
      checkOutput("sw_wait_memwrite", bus.MemWrite, 1);
      if (i == 3) bus.MemReady = 1'b1;
    end
`else
    nextCycle();
    checkState("sw_memwrite_state", 5);
    checkOutput("sw_memwrite", bus.MemWrite, 1);
`endif
    nextCycle();
    checkState("sw_done_state", 0);
    checkOutput("sw_done_memwrite", bus.MemWrite, 0);
    bus.MemReady = 1'b1;
    pulseReset("sw_realign_reset");

`ifdef MC_CTRL_MEM_WAIT_EN
    bus.MemReady = 1'b0;
    #1;
    checkOutput("fetch_wait_irwrite", bus.IRWrite, 0);
    checkOutput("fetch_wait_pcwrite", bus.PCWrite, 0);
    nextCycle();
    checkState("fetch_wait_hold", 0);
    bus.MemReady = 1'b1;
`endif

    // beq
    applyStimulus(OP_BEQ, 3'b000, 1'b0, 1'b0, 1'b1);
    nextCycle();
    checkState("beq_decode", 1);
    nextCycle();
    checkState("beq_state", 10);
    checkOutput("beq_alucontrol", bus.ALUControl, 1);
    checkOutput("beq_immsrc", bus.ImmSrc, 2);
    bus.Zero = 1'b1;
    #1;
    checkOutput("beq_taken_pcwrite", bus.PCWrite, 1);
    bus.Zero = 1'b0;
    #1;
    checkOutput("beq_nottaken_pcwrite", bus.PCWrite, 0);
    nextCycle();
    checkState("beq_back_fetch", 0);

    // R-type sub
    applyStimulus(OP_R, 3'b000, 1'b1, 1'b0, 1'b1);
    nextCycle();
    checkState("rsub_decode", 1);
    nextCycle();
    checkState("rsub_exec", 6);
    checkOutput("rsub_alucontrol", bus.ALUControl, 1);
    checkOutput("rsub_alusrca", bus.ALUSrcA, 2);
    checkOutput("rsub_alusrcb", bus.ALUSrcB, 0);
    nextCycle();
    checkState("rsub_aluwb", 7);
    checkOutput("rsub_regwrite", bus.RegWrite, 1);
    checkOutput("rsub_resultsrc", bus.ResultSrc, 0);
    nextCycle();
    checkState("rsub_fetch", 0);

    // R-type slt
    applyStimulus(OP_R, 3'b010, 1'b0, 1'b0, 1'b1);
    nextCycle();
    nextCycle();
    checkState("rslt_exec", 6);
    checkOutput("rslt_alucontrol", bus.ALUControl, 5);
    nextCycle();
    checkState("rslt_aluwb", 7);
    nextCycle();
    checkState("rslt_fetch", 0);

    // addi with funct7b5 set still adds
    applyStimulus(OP_I, 3'b000, 1'b1, 1'b0, 1'b1);
    nextCycle();
    nextCycle();
    checkState("addi_exec", 8);
    checkOutput("addi_alucontrol", bus.ALUControl, 0);
    checkOutput("addi_alusrcb", bus.ALUSrcB, 1);
    nextCycle();
    checkState("addi_aluwb", 7);
    nextCycle();
    checkState("addi_fetch", 0);

    // jal
    applyStimulus(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1);
    nextCycle();
    nextCycle();
    checkState("jal_state", 9);
    checkOutput("jal_pcwrite", bus.PCWrite, 1);
    checkOutput("jal_immsrc", bus.ImmSrc, 3);
    checkOutput("jal_alusrca", bus.ALUSrcA, 1);
    nextCycle();
    checkState("jal_aluwb", 7);
    checkOutput("jal_regwrite", bus.RegWrite, 1);
    nextCycle();
    checkState("jal_fetch", 0);

    // unsupported opcode traps and sticks
    applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b1, 1'b1);
    nextCycle();
    checkState("illegal_decode", 1);
    for (int i = 0; i < 11; i++) begin
      nextCycle();
      checkState("illegal_state", 11);
      checkOutput("illegal_flag", bus.Illegal, 1);
      checkOutput("illegal_enables",
                  {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite}, 0);
    end
    pulseReset("illegal_reset");
    checkOutput("illegal_cleared", bus.Illegal, 0);

    // reset in the middle of EXECUTER
    applyStimulus(OP_R, 3'b000, 1'b0, 1'b0, 1'b1);
    nextCycle();
    nextCycle();
    checkState("midexec_state", 6);
    reset = 1'b1;
    #1;
    checkState("midexec_reset_state", 0);
    checkOutput("midexec_reset_alusrcb", bus.ALUSrcB, 2);
    checkOutput("midexec_reset_regwrite", bus.RegWrite, 0);
    @(negedge clk);
    reset = 1'b0;

    // reset in the middle of MEMWRITE abandons the store
    applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1);
    nextCycle();
    nextCycle();
    bus.MemReady = 1'b0;
    nextCycle();
    checkState("midsw_state", 5);
    checkOutput("midsw_memwrite", bus.MemWrite, 1);
    reset = 1'b1;
    #1;
    checkState("midsw_reset_state", 0);
    checkOutput("midsw_reset_memwrite", bus.MemWrite, 0);
    @(negedge clk);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, failCount);
    $finish;
  end

endmodule
